nibble_serial_adder: RTL and testbench

Multi-word adder that streams two wide operands through the existing 4-bit ripple-carry adder (`rcarry_4bit`) one nibble per clock, least-significant nibble first. It registers each 4-bit carry-out and feeds it back as the next nibble's carry-in. It sits directly upstream of `rcarry_4bit` and drives its `a`, `b` and `cin`. It also sits downstream of it, collecting `s` and `cout` into a wide sum with a start/busy/done handshake.

---
 rtl/nsa_pkg.sv | 18 +
 rtl/rcarry_4bit.sv | 23 ++
 rtl/nibble_serial_adder.sv | 118 +++++++++++
 tb/tb_nibble_serial_adder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/nsa_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding,
// nibble width and the nibble counter width helper.
package nsa_pkg;

    localparam int NSA_NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } nsa_state_t;

    // Bits needed to count 0..n inclusive.
    function automatic int nsa_cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/rcarry_4bit.sv
// 4-bit ripple-carry adder used as the nibble datapath.
// Ports: a, b (4b operands), cin (carry in), s (4b sum), cout (carry out).
module rcarry_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic c;

    always_comb begin
        c = cin;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-word adder streaming operands one nibble per clock, LSN first,
// through rcarry_4bit with a registered carry between nibbles.
// Ports: clk, rst_n (sync, active-low), start, a, b, cin, [sub],
//        busy, done (1-cycle pulse), sum, cout.
// Optional: define NSA_SUB_EN to add the sub port (A - B as A + ~B + 1).
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [NIBBLES*NSA_NIBBLE_W-1:0] a,
    input  logic [NIBBLES*NSA_NIBBLE_W-1:0] b,
    input  logic                          cin,
`ifdef NSA_SUB_EN
    input  logic                          sub,
`endif
    output logic                          busy,
    output logic                          done,
    output logic [NIBBLES*NSA_NIBBLE_W-1:0] sum,
    output logic                          cout
);

    localparam int W  = NIBBLES * NSA_NIBBLE_W;
    localparam int CW = nsa_cnt_w(NIBBLES);

    nsa_state_t state, state_nx;

    logic [W-1:0]  a_sr;
    logic [W-1:0]  b_sr;
    logic [W-1:0]  res_sr;
    logic [W-1:0]  res_nx;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          last;
    logic [3:0]    add_s;
    logic          add_c;
    logic [W-1:0]  b_load;
    logic          c_load;

    rcarry_4bit u_add (
        .a    (a_sr[3:0]),
        .b    (b_sr[3:0]),
        .cin  (carry),
        .s    (add_s),
        .cout (add_c)
    );

`ifdef NSA_SUB_EN
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    assign last = (cnt == CW'(NIBBLES - 1));

    // New nibble enters at the top; after NIBBLES shifts the LSN
    // sits at the bottom. Shift form keeps NIBBLES=1 legal.
    assign res_nx = (res_sr >> NSA_NIBBLE_W)
                  | (W'(add_s) << (W - NSA_NIBBLE_W));

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx == RUN);
            done  <= (state_nx == DONE);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b_load;
                        carry  <= c_load;
                        res_sr <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> NSA_NIBBLE_W;
                    b_sr   <= b_sr >> NSA_NIBBLE_W;
                    res_sr <= res_nx;
                    carry  <= add_c;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        sum  <= res_nx;
                        cout <= add_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (NIBBLES=4):
// table-driven operations plus ignored-start and mid-run reset sequences.
module tb_nibble_serial_adder;

    localparam int N = 4;
    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef NSA_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int total;
    int bad;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    vec_t vecs[$];

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef NSA_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input string nm);
        logic [W-1:0] ref_s;
        logic         ref_c;
        int           busy_n;
        int           done_at;
        int           both;
        int           unstable;
        logic [W-1:0] cap_s;
        logic         cap_c;
        ref_s    = sum;
        ref_c    = cout;
        busy_n   = 0;
        done_at  = 0;
        both     = 0;
        unstable = 0;
        cap_s    = '0;
        cap_c    = 1'b0;
        @(negedge clk);
        a     = v.a;
        b     = v.b;
        cin   = v.cin;
`ifdef NSA_SUB_EN
        sub   = v.sub;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
`ifdef NSA_SUB_EN
        sub   = 1'($urandom);
`endif
        for (int k = 1; k <= N + 4; k++) begin
            if (k > 1) @(negedge clk);
            if (busy) busy_n++;
            if (busy && done) both++;
            if (done && done_at == 0) begin
                done_at = k;
                cap_s   = sum;
                cap_c   = cout;
                ref_s   = sum;
                ref_c   = cout;
            end
            if (sum !== ref_s || cout !== ref_c) unstable++;
        end
        check({nm, " busy_cycles"}, busy_n, N);
        check({nm, " done_cycle"}, done_at, N + 1);
        check({nm, " sum"}, cap_s, v.sum);
        check({nm, " cout"}, cap_c, v.cout);
        check({nm, " stable"}, unstable, 0);
        check({nm, " busy_and_done"}, both, 0);
    endtask

    initial begin
        int seen_done;
        int seen_busy;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
`ifdef NSA_SUB_EN
        sub   = 1'b0;
`endif

        vecs.push_back('{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0});
        vecs.push_back('{16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0});
        vecs.push_back('{16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 16'hFFFF, 1'b0});
`ifdef NSA_SUB_EN
        vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0});
        vecs.push_back('{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1});
`endif

        repeat (2) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset sum", sum, 0);
        check("reset cout", cout, 0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            run_op(vecs[i], $sformatf("vec%0d", i));

        // start pulses during RUN and DONE must be ignored
        @(negedge clk);
        a     = 16'h0001;
        b     = 16'h0001;
        cin   = 1'b0;
`ifdef NSA_SUB_EN
        sub   = 1'b0;
`endif
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        seen_done = 0;
        seen_busy = 0;
        @(negedge clk);
        a     = 16'hAAAA;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4 && !done; k++) @(negedge clk);
        check("ign done", done, 1);
        check("ign sum", sum, 16'h0002);
        check("ign cout", cout, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (done) seen_done++;
            if (busy) seen_busy++;
            @(negedge clk);
        end
        check("ign no_requeue_busy", seen_busy, 0);
        check("ign no_extra_done", seen_done, 0);

        // reset during the third RUN cycle
        @(negedge clk);
        a     = 16'h1111;
        b     = 16'h2222;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst busy_before", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst sum", sum, 0);
        check("rst cout", cout, 0);
        seen_done = 0;
        for (int k = 0; k < 6; k++) begin
            if (done) seen_done++;
            @(negedge clk);
        end
        check("rst no_done", seen_done, 0);
        run_op(vecs[0], "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
